// File: rtl/branch_resolve_unit_if.sv
// Bundle between the EX stage, fetch and the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned CNT_BITS = 32
);
  logic            ex_valid;
  logic            ex_branch;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            br_eq;
  logic            br_lt;
  logic            br_un;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush;
  logic            ex_stall;
  logic [CNT_BITS-1:0] branch_cnt;
  logic [CNT_BITS-1:0] mispred_cnt;

  // Pipeline/fetch side
  modport master (
    output ex_valid, ex_branch, ex_funct3, ex_pc, ex_target, ex_pred_taken,
    output br_eq, br_lt, if_pc, redirect_ready,
    input  br_un, if_pred_taken, redirect_valid, redirect_pc, flush, ex_stall,
    input  branch_cnt, mispred_cnt
  );

  // Branch resolve unit side
  modport slave (
    input  ex_valid, ex_branch, ex_funct3, ex_pc, ex_target, ex_pred_taken,
    input  br_eq, br_lt, if_pc, redirect_ready,
    output br_un, if_pred_taken, redirect_valid, redirect_pc, flush, ex_stall,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes funct3 against BrEq/BrLT, detects mispredicts,
// drives a held redirect to fetch, owns a 2-bit-counter BHT and perf counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter int unsigned CNT_BITS     = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam int unsigned BHT_ENTRIES = 2 ** BHT_IDX_BITS;

  state_t state, stateNext;

  logic [1:0]          bht [BHT_ENTRIES];
  logic [XLEN-1:0]     redirectPc;
  logic                flushQ;
  logic                flushNext;
  logic                loadRedirect;
  logic [CNT_BITS-1:0] branchCnt;
  logic [CNT_BITS-1:0] mispredCnt;

  logic                redirectValid;
  logic                exStall;
  logic                resolve;
  logic                taken;
  logic                legal;
  logic                mispredict;
  logic [XLEN-1:0]     correctPc;
  logic [BHT_IDX_BITS-1:0] exIdx;
  logic [BHT_IDX_BITS-1:0] ifIdx;
  logic                unusedIfPc;

  assign redirectValid = (state == REDIRECT);
  assign exStall       = redirectValid & ~bus.redirect_ready;
  assign resolve       = bus.ex_valid & bus.ex_branch & ~exStall;
  assign mispredict    = resolve & (taken != bus.ex_pred_taken);
  assign correctPc     = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
  assign exIdx         = bus.ex_pc[BHT_IDX_BITS+1:2];
  assign ifIdx         = bus.if_pc[BHT_IDX_BITS+1:2];
  assign unusedIfPc    = ^{bus.if_pc[XLEN-1:BHT_IDX_BITS+2], bus.if_pc[1:0]};

  assign bus.br_un          = bus.ex_funct3[1];
  assign bus.if_pred_taken  = bht[ifIdx][1];
  assign bus.redirect_valid = redirectValid;
  assign bus.redirect_pc    = redirectPc;
  assign bus.flush          = flushQ;
  assign bus.ex_stall       = exStall;
  assign bus.branch_cnt     = branchCnt;
  assign bus.mispred_cnt    = mispredCnt;

  // Decode funct3 into taken; 010/011 are illegal and never taken
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    unique case (bus.ex_funct3)
      3'b000:          taken = bus.br_eq;
      3'b001:          taken = ~bus.br_eq;
      3'b100, 3'b110:  taken = bus.br_lt;
      3'b101, 3'b111:  taken = ~bus.br_lt;
      default:         legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // FSM next state, redirect load and flush request
  always_comb begin
    stateNext    = state;
    loadRedirect = 1'b0;
    flushNext    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mispredict) begin
          loadRedirect = 1'b1;
          stateNext    = REDIRECT;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          flushNext = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Redirect target and one-cycle flush pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      redirectPc <= '0;
      flushQ     <= 1'b0;
    end else begin
      flushQ <= flushNext;
      if (loadRedirect) redirectPc <= correctPc;
    end
  end

  // BHT update; lookup is a combinational read so same-cycle reads see the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve && legal) begin
      if (taken && bht[exIdx] != 2'b11)       bht[exIdx] <= bht[exIdx] + 2'b01;
      else if (!taken && bht[exIdx] != 2'b00) bht[exIdx] <= bht[exIdx] - 2'b01;
    end
  end

  // Saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else begin
      if (resolve && branchCnt != '1)     branchCnt  <= branchCnt + 1'b1;
      if (mispredict && mispredCnt != '1) mispredCnt <= mispredCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  branch_resolve_unit_if #(.XLEN(64), .CNT_BITS(32)) bus ();

  branch_resolve_unit #(.XLEN(64), .BHT_IDX_BITS(6), .CNT_BITS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic eq, input logic lt,
                       input logic pred, input logic [63:0] pc, input logic [63:0] tgt);
    bus.ex_valid      = 1'b1;
    bus.ex_branch     = 1'b1;
    bus.ex_funct3     = f3;
    bus.br_eq         = eq;
    bus.br_lt         = lt;
    bus.ex_pred_taken = pred;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.ex_branch = 1'b0;
  endtask

  // Stimulus and checks
  initial begin
    idle();
    bus.ex_funct3 = 3'b000; bus.br_eq = 1'b0; bus.br_lt = 1'b0;
    bus.ex_pred_taken = 1'b0; bus.ex_pc = '0; bus.ex_target = '0;
    bus.if_pc = '0; bus.redirect_ready = 1'b0;

    // T1 reset
    tick(); tick();
    rst = 1'b0;
    checkEq("rst_rv", bus.redirect_valid, 0);
    checkEq("rst_rpc", bus.redirect_pc, 0);
    checkEq("rst_flush", bus.flush, 0);
    checkEq("rst_bcnt", bus.branch_cnt, 0);
    checkEq("rst_mcnt", bus.mispred_cnt, 0);
    checkEq("rst_stall", bus.ex_stall, 0);
    bus.if_pc = 64'h0;  #1 checkEq("rst_pred0", bus.if_pred_taken, 0);
    bus.if_pc = 64'hFC; #1 checkEq("rst_predFC", bus.if_pred_taken, 0);

    // T2 correct taken BEQ (idx0 01->10)
    drive(3'b000, 1'b1, 1'b0, 1'b1, 64'h100, 64'h180);
    #1 checkEq("t2_brun", bus.br_un, 0);
    tick(); idle();
    checkEq("t2_rv", bus.redirect_valid, 0);
    checkEq("t2_bcnt", bus.branch_cnt, 1);
    checkEq("t2_mcnt", bus.mispred_cnt, 0);
    bus.if_pc = 64'h100; #1 checkEq("t2_pred", bus.if_pred_taken, 1);

    // T3 BLT not taken, predicted taken, immediate accept (idx0 10->01)
    drive(3'b100, 1'b0, 1'b0, 1'b1, 64'h200, 64'h300);
    tick(); idle();
    checkEq("t3_rv", bus.redirect_valid, 1);
    checkEq("t3_rpc", bus.redirect_pc, 64'h204);
    checkEq("t3_mcnt", bus.mispred_cnt, 1);
    bus.redirect_ready = 1'b1;
    #1 checkEq("t3_stall_rdy", bus.ex_stall, 0);
    tick(); bus.redirect_ready = 1'b0;
    checkEq("t3_flush", bus.flush, 1);
    checkEq("t3_rv_drop", bus.redirect_valid, 0);
    tick();
    checkEq("t3_flush_off", bus.flush, 0);
    bus.if_pc = 64'h0; #1 checkEq("t3_pred", bus.if_pred_taken, 0);

    // T4 BGEU taken, predicted not-taken, delayed accept (idx0 01->10)
    drive(3'b111, 1'b0, 1'b0, 1'b0, 64'h300, 64'h40);
    #1 checkEq("t4_brun", bus.br_un, 1);
    tick();
    drive(3'b000, 1'b1, 1'b0, 1'b0, 64'h504, 64'h900);
    for (int i = 0; i < 3; i++) begin
      checkEq("t4_rv_hold", bus.redirect_valid, 1);
      checkEq("t4_rpc_hold", bus.redirect_pc, 64'h40);
      checkEq("t4_stall", bus.ex_stall, 1);
      tick();
    end
    idle();
    checkEq("t4_bcnt", bus.branch_cnt, 3);
    checkEq("t4_mcnt", bus.mispred_cnt, 2);
    bus.if_pc = 64'h504; #1 checkEq("t4_stalled_bht", bus.if_pred_taken, 0);
    bus.redirect_ready = 1'b1;
    tick(); bus.redirect_ready = 1'b0;
    checkEq("t4_flush", bus.flush, 1);
    checkEq("t4_rv_drop", bus.redirect_valid, 0);
    tick();
    checkEq("t4_flush_off", bus.flush, 0);

    // T5 saturation at idx4: 4 taken, then two not-taken
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 1'b1, 1'b0, 1'b1, 64'h10, 64'h80);
      tick();
    end
    idle();
    bus.if_pc = 64'h10; #1 checkEq("t5_sat11", bus.if_pred_taken, 1);
    drive(3'b001, 1'b1, 1'b0, 1'b0, 64'h10, 64'h80);
    tick(); idle();
    #1 checkEq("t5_dec10", bus.if_pred_taken, 1);
    drive(3'b001, 1'b1, 1'b0, 1'b0, 64'h10, 64'h80);
    tick(); idle();
    #1 checkEq("t5_dec01", bus.if_pred_taken, 0);
    checkEq("t5_rv", bus.redirect_valid, 0);
    checkEq("t5_bcnt", bus.branch_cnt, 9);

    // T5 wrap: not-taken mispredict at top of address space
    drive(3'b000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h80);
    tick(); idle();
    checkEq("t5_wrap_rv", bus.redirect_valid, 1);
    checkEq("t5_wrap_rpc", bus.redirect_pc, 0);
    checkEq("t5_mcnt", bus.mispred_cnt, 3);

    // T6 reset while in REDIRECT
    bus.if_pc = 64'h0; #1 checkEq("t6_pred_pre", bus.if_pred_taken, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkEq("t6_rv", bus.redirect_valid, 0);
    checkEq("t6_flush", bus.flush, 0);
    checkEq("t6_bcnt", bus.branch_cnt, 0);
    checkEq("t6_pred_reinit", bus.if_pred_taken, 0);
    tick();
    checkEq("t6_flush_later", bus.flush, 0);

    // T6 illegal funct3: raise idx0 to 10, then illegal must leave it
    drive(3'b000, 1'b1, 1'b0, 1'b1, 64'h0, 64'h80);
    tick();
    drive(3'b010, 1'b1, 1'b1, 1'b1, 64'h0, 64'h900);
    #1 checkEq("t6_brun", bus.br_un, 1);
    tick(); idle();
    checkEq("t6_ill_rv", bus.redirect_valid, 1);
    checkEq("t6_ill_rpc", bus.redirect_pc, 64'h4);
    checkEq("t6_ill_bcnt", bus.branch_cnt, 2);
    checkEq("t6_ill_mcnt", bus.mispred_cnt, 1);
    bus.if_pc = 64'h0; #1 checkEq("t6_ill_bht", bus.if_pred_taken, 1);
    bus.redirect_ready = 1'b1;
    tick(); bus.redirect_ready = 1'b0;
    checkEq("t6_ill_flush", bus.flush, 1);
    tick();
    checkEq("t6_ill_flush_off", bus.flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
